// File: rtl/bin2bcd_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_ctrl_if
// Handshake and result bundle between the calculator core (master) and the
// sequential binary-to-BCD converter (slave).
//   start        : conversion request, core -> converter
//   numero       : unsigned binary operand, core -> converter
//   busy         : conversion in progress, converter -> core
//   done         : one-cycle completion pulse, converter -> core
//   ovf          : operand did not fit in eight decimal digits
//   num0..num7   : registered BCD digits, num0 = units, num7 = 10^7
// ---------------------------------------------------------------------------
interface bin2bcd_seq_ctrl_if #(
    parameter int WIDTH = 27
);
    logic             start;
    logic [WIDTH-1:0] numero;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       num0;
    logic [3:0]       num1;
    logic [3:0]       num2;
    logic [3:0]       num3;
    logic [3:0]       num4;
    logic [3:0]       num5;
    logic [3:0]       num6;
    logic [3:0]       num7;

    modport master (
        output start, numero,
        input  busy, done, ovf,
        input  num0, num1, num2, num3, num4, num5, num6, num7
    );

    modport slave (
        input  start, numero,
        output busy, done, ovf,
        output num0, num1, num2, num3, num4, num5, num6, num7
    );
endinterface

// File: rtl/bin2bcd_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_ctrl
// Iterative shift-add-3 (double-dabble) binary-to-BCD converter for the
// calculator display path. One conversion takes WIDTH shift cycles after the
// accepting edge; results and the overflow flag are registered and held
// until the next completion.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : bin2bcd_seq_ctrl_if.slave (start/numero in; busy/done/ovf/num0..7 out)
//
// Build option:
//   LEADING_ZERO_BLANK_EN - when defined, leading zero digits num7..num1 are
//   replaced by 4'hF (7-seg blank code) at completion, unless ovf is set.
// ---------------------------------------------------------------------------
module bin2bcd_seq_ctrl #(
    parameter int WIDTH  = 27,
    parameter int DIGITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    bin2bcd_seq_ctrl_if.slave  bus
);

    localparam int SCR_W = DIGITS * 4;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);
    // Smallest operand that needs a ninth decimal digit.
    localparam logic [63:0] OVF_LIMIT = 64'd100000000;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q,    state_d;
    logic [WIDTH-1:0] bin_q,      bin_d;
    logic [SCR_W-1:0] scratch_q,  scratch_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             ovf_q,      ovf_d;
    logic             done_q,     done_d;
    logic [SCR_W-1:0] num_q,      num_d;

    logic [SCR_W-1:0]       scratch_adj;
    logic [SCR_W+WIDTH-1:0] shifted;
    logic [SCR_W-1:0]       res_digits;

    // Add-3 correction on every nibble that would reach >= 10 after doubling.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign scratch_adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5)
                                          ? scratch_q[gi*4 +: 4] + 4'd3
                                          : scratch_q[gi*4 +: 4];
        end
    endgenerate

    // The bit shifted out of the top digit is dropped, so the digits end up
    // holding the operand modulo 10^DIGITS.
    assign shifted = {scratch_adj, bin_q} << 1;

    // Digits as they will look after the final shift.
    always_comb begin
        res_digits = shifted[WIDTH +: SCR_W];
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic leading;
            // An overflowed value is shown in full so the truncation is visible.
            leading = !ovf_pend_q;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (leading && (res_digits[i*4 +: 4] == 4'd0)) begin
                    res_digits[i*4 +: 4] = 4'hF;
                end else begin
                    leading = 1'b0;
                end
            end
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        num_d      = num_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    bin_d      = bus.numero;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (64'(bus.numero) >= OVF_LIMIT);
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = shifted[WIDTH +: SCR_W];
                bin_d     = shifted[WIDTH-1:0];
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_SHIFT) begin
                    num_d   = res_digits;
                    ovf_d   = ovf_pend_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            num_q      <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            num_q      <= num_d;
        end
    end

    assign bus.busy = (state_q == ST_SHIFT);
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
    assign bus.num0 = num_q[3:0];
    assign bus.num1 = num_q[7:4];
    assign bus.num2 = num_q[11:8];
    assign bus.num3 = num_q[15:12];
    assign bus.num4 = num_q[19:16];
    assign bus.num5 = num_q[23:20];
    assign bus.num6 = num_q[27:24];
    assign bus.num7 = num_q[31:28];

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq_ctrl
// Self-checking bench for bin2bcd_seq_ctrl: directed corner operands plus
// random operands, compared against an arithmetic decimal reference model.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq_ctrl;

    localparam int WIDTH   = 27;
    localparam int LATENCY = 27;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    bin2bcd_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    bin2bcd_seq_ctrl #(.WIDTH(WIDTH), .DIGITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] digits_now();
        return {bus.num7, bus.num6, bus.num5, bus.num4,
                bus.num3, bus.num2, bus.num1, bus.num0};
    endfunction

    // Decimal digits of the operand mod 10^8, by repeated division.
    function automatic logic [31:0] model_digits(input int unsigned op);
        logic [31:0]  r;
        int unsigned  v;
        int           sig;
        v = op % 100000000;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (op < 100000000) begin
            // Count significant decimal digits (0 still shows one digit).
            sig = 1;
            v   = op / 10;
            while (v != 0) begin
                sig++;
                v = v / 10;
            end
            for (int i = sig; i < 8; i++) r[i*4 +: 4] = 4'hF;
        end
`else
        sig = 0;
`endif
        return r;
    endfunction

    // Runs one conversion from the current negedge. pre_armed: start/numero
    // were already driven (back-to-back). hold: keep start high while busy.
    // alt: value put on numero mid-conversion. chain/chain_op: raise start
    // again in the done cycle.
    task automatic run_conv(input int unsigned op, input bit pre_armed, input bit hold,
                            input int unsigned alt, input bit chain, input int unsigned chain_op);
        int          cyc;
        int          busy_cnt;
        bit          seen;
        logic [31:0] exp_d;
        if (!pre_armed) begin
            bus.start  = 1'b1;
            bus.numero = WIDTH'(op);
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        busy_cnt = bus.busy ? 1 : 0;
        check("done_low_after_accept", bus.done, 1'b0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 5) bus.numero = WIDTH'(alt);
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_cnt++;
        end
        exp_d = model_digits(op);
        check("latency", 64'(cyc), 64'(LATENCY));
        check("busy_cycles", 64'(busy_cnt), 64'(LATENCY));
        check("busy_low_at_done", bus.busy, 1'b0);
        check("digits", digits_now(), exp_d);
        check("ovf", bus.ovf, (op >= 100000000) ? 1'b1 : 1'b0);
        $display("conv op=%0d digits=%08h ovf=%0b latency=%0d", op, digits_now(), bus.ovf, cyc);
        if (chain) begin
            bus.start  = 1'b1;
            bus.numero = WIDTH'(chain_op);
        end else begin
            bus.start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("done_one_cycle", bus.done, 1'b0);
            check("result_hold", digits_now(), exp_d);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_ovf"}, bus.ovf, 1'b0);
        check({tag, "_digits"}, digits_now(), 32'h0);
    endtask

    initial begin
        int done_seen;
        int unsigned op;
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.numero = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero_outputs("reset");

        // Idle with start low: nothing may move.
        done_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        check("idle_activity", 64'(done_seen), 64'd0);
        check_zero_outputs("idle");
        $display("idle 50 cycles activity=%0d", done_seen);

        // Directed corners.
        run_conv(12345678,  1'b0, 1'b0, 3,   1'b0, 0);
        run_conv(0,         1'b0, 1'b0, 5,   1'b0, 0);
        run_conv(1000,      1'b0, 1'b0, 7,   1'b0, 0);
        run_conv(99999999,  1'b0, 1'b0, 1,   1'b0, 0);
        run_conv(134217727, 1'b0, 1'b0, 0,   1'b0, 0);
        run_conv(100000000, 1'b0, 1'b0, 0,   1'b0, 0);
        // Start held and operand changed mid-conversion, then back-to-back.
        run_conv(555,       1'b0, 1'b1, 777, 1'b1, 42);
        run_conv(42,        1'b1, 1'b0, 999, 1'b0, 0);

        // Random operands, with random back-to-back chaining.
        op = $urandom_range(0, (1 << WIDTH) - 1);
        for (int i = 0; i < 20; i++) begin
            int unsigned nxt;
            bit          chn;
            nxt = $urandom_range(0, (1 << WIDTH) - 1);
            chn = (i != 19) && ($urandom_range(0, 1) == 1);
            run_conv(op, (i > 0) && bus.start, 1'b0, $urandom_range(0, (1 << WIDTH) - 1), chn, nxt);
            op = nxt;
        end

        // Reset in the middle of a conversion: immediate abort, no done.
        bus.start  = 1'b1;
        bus.numero = WIDTH'(87654321);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        check_zero_outputs("after_abort");
        $display("abort at cycle 10 activity_after=%0d", done_seen);

        run_conv(9, 1'b0, 1'b0, 4, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq_ctrl.md
Name: bin2bcd_seq_ctrl

Overview:
- Sequenced binary-to-BCD conversion controller for the calculator display path.
- Replaces the combinational divide/modulo chain with an iterative shift-add-3 (double-dabble) engine.
- Driven by a start/busy/done handshake from the calculator core; produces eight registered BCD digits for the 7-segment decoders.
- Flags operands that do not fit in eight decimal digits.

Parameters:
- WIDTH, 27, binary operand width; sets the number of shift iterations.
- DIGITS, 8, number of BCD digits produced; fixed at 8 for this port list.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, conversion request; sampled only when not busy.
- numero, input, WIDTH, unsigned binary operand; captured on the accepting edge.
- busy, output, 1, high while a conversion is in progress.
- done, output, 1, one-cycle pulse when results are updated.
- ovf, output, 1, registered: 1 when the captured operand is >= 100000000.
- num0..num7, output, 4 each, registered BCD digits; num0 = units, num7 = 10^7.

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, done=0, ovf=0, num0..num7=0, shift counter=0, internal regs cleared.
- States:
  - IDLE: busy=0. On an edge with start=1: capture numero into bin shift reg, clear 32-bit BCD scratch, clear counter, go to SHIFT, busy=1.
  - SHIFT: busy=1. Each edge:
    - every scratch nibble >= 5 gets +3 (combinational);
    - then shift {scratch, bin} left by 1;
    - counter increments.
  - On the edge performing shift number WIDTH:
    - load num0..num7 from the resulting scratch;
    - load ovf from the operand-size comparison made at capture;
    - done=1, busy=0, state IDLE.
- Latency: start accepted at edge E0; done high in the cycle following edge E(WIDTH), i.e. 27 cycles for the defaults. Fixed, independent of operand value.
- done is high for exactly one cycle and is cleared on the next edge.
- Back-to-back: start=1 during the done cycle is accepted, since the state is already IDLE. Throughput is one conversion per WIDTH+1 cycles.
- start while busy: ignored, with no queuing.
- numero changes while busy: ignored; only the captured value is converted.
- Outputs hold the last result until the next completion; they are not cleared on start.
- Overflow: the carry out of num7 is discarded, so digits = operand mod 10^8. ovf=1 iff operand >= 10^8 (max 2^27-1 = 134217727).
- Reset mid-conversion: abort immediately, all outputs take their reset values, no done pulse.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - at the completion edge, each leading-zero digit from num7 down to num1 is replaced by 4'hF (blank code for the 7-seg decoder);
  - num0 is never blanked;
  - blanking stops at the first nonzero digit;
  - when ovf=1, no blanking is applied.
- Undefined: raw BCD digits, leading zeros included.

Test Plan:
- Reset -> busy=0, done=0, ovf=0, num0..num7=0; start held low for 50 cycles -> no change.
- numero=12345678, start for 1 cycle -> done exactly 27 cycles after the accepting edge; num7..num0=1,2,3,4,5,6,7,8; ovf=0; busy high for 27 cycles.
- numero=0 -> all digits 0. With LEADING_ZERO_BLANK_EN: num7..num1=F, num0=0. numero=1000 with the macro -> num7..num4=F, num3..num0=1,0,0,0.
- numero=99999999 -> all digits 9, ovf=0. numero=134217727 -> digits 3,4,2,1,7,7,2,7 (num7..num0), ovf=1.
- numero=555 with start held and numero switched to 777 mid-conversion -> result 555. start in the done cycle with numero=42 -> second done 27 cycles later with num1=4, num0=2.
- rst pulsed at cycle 10 of a conversion -> outputs zero, no done. A new start with numero=9 -> num0=9 after 27 cycles.
